adam_periph_spi_target: RTL and testbench

ADAM_PERIPH_SPI_TARGET -- requirements
Module: adam_periph_spi_target

---
 rtl/adam_periph_spi_target_if.sv | 22 ++
 rtl/adam_periph_spi_target.sv | 231 +++++++++++++++++++++++
 tb/tb_adam_periph_spi_target.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/adam_periph_spi_target_if.sv
// rtl/adam_periph_spi_target_if.sv - register access bus between the SPI target and a register file
interface adam_periph_spi_target_if #(
  parameter int ADDR_WIDTH = 7
);
  logic                  reg_req;
  logic                  reg_we;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [7:0]            reg_wdata;
  logic                  reg_gnt;
  logic                  reg_rvalid;
  logic [7:0]            reg_rdata;

  modport master (
    output reg_req, reg_we, reg_addr, reg_wdata,
    input  reg_gnt, reg_rvalid, reg_rdata
  );

  modport slave (
    input  reg_req, reg_we, reg_addr, reg_wdata,
    output reg_gnt, reg_rvalid, reg_rdata
  );
endinterface

// File: rtl/adam_periph_spi_target.sv
// rtl/adam_periph_spi_target.sv - SPI target bridging framed SPI transfers onto a register bus
module adam_periph_spi_target #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_WIDTH  = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     clock_polarity,
  input  logic                     clock_phase,
  input  logic                     data_order,
  input  logic                     sclk_i,
  input  logic                     ss_n_i,
  input  logic                     mosi_i,
  output logic                     miso_o,
  output logic                     miso_oe,
  adam_periph_spi_target_if.master bus,
  output logic                     busy,
  output logic                     err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_WRITE,
    ST_READ
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   ss_prev_q, ss_prev_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             rx_shift_q, rx_shift_d;
  logic [7:0]             tx_shift_q, tx_shift_d;
  logic [7:0]             tx_buf_q, tx_buf_d;
  logic                   tx_valid_q, tx_valid_d;
  logic                   rd_wait_q, rd_wait_d;
  logic                   req_q, req_d;
  logic                   we_q, we_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [7:0]             wdata_q, wdata_d;
  logic                   oe_q, oe_d;
  logic                   err_q, err_d;

  logic                   sclk_s, ss_s, mosi_s;
  logic                   sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic                   in_frame, sample_edge, shift_edge;
  logic                   ss_fall, ss_rise, abort;
  logic                   byte_done, load_point, gnt_hit;
  logic [7:0]             rx_next;
  logic [ADDR_WIDTH-1:0]  addr_adv;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise  = sclk_s & ~sclk_prev_q;
  assign sclk_fall  = ~sclk_s & sclk_prev_q;
  assign lead_edge  = clock_polarity ? sclk_fall : sclk_rise;
  assign trail_edge = clock_polarity ? sclk_rise : sclk_fall;

  assign in_frame    = (state_q != ST_IDLE);
  assign sample_edge = in_frame & (clock_phase ? trail_edge : lead_edge);
  assign shift_edge  = in_frame & (clock_phase ? lead_edge : trail_edge);

  assign ss_fall = ss_prev_q & ~ss_s;
  assign ss_rise = ~ss_prev_q & ss_s;
  assign abort   = in_frame & (ss_rise | ~enable);

  assign rx_next    = data_order ? {rx_shift_q[6:0], mosi_s} : {mosi_s, rx_shift_q[7:1]};
  assign byte_done  = sample_edge & (bit_cnt_q == 3'd7);
  // The shift edge seen with a zero bit count is the first shift of a new byte.
  assign load_point = shift_edge & (bit_cnt_q == 3'd0);
  assign gnt_hit    = req_q & bus.reg_gnt;
  assign addr_adv   = gnt_hit ? addr_q + ADDR_WIDTH'(1) : addr_q;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss_n_i};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
    sclk_prev_d = sclk_s;
    ss_prev_d   = ss_s;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    tx_buf_d    = tx_buf_q;
    tx_valid_d  = tx_valid_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_adv;
    wdata_d     = wdata_q;
    oe_d        = enable & ~ss_s;
    err_d       = 1'b0;

    if (gnt_hit) begin
      req_d = 1'b0;
    end

    // Only responses to reads granted inside the current READ frame reach the buffer.
    rd_wait_d = (rd_wait_q & ~bus.reg_rvalid) | (gnt_hit & ~we_q & (state_q == ST_READ));
    if (rd_wait_q && bus.reg_rvalid && (state_q == ST_READ)) begin
      tx_buf_d   = bus.reg_rdata;
      tx_valid_d = 1'b1;
    end

    if (abort) begin
      state_d    = ST_IDLE;
      err_d      = ss_rise & enable & (bit_cnt_q != 3'd0);
      bit_cnt_d  = 3'd0;
      tx_shift_d = 8'h00;
      tx_valid_d = 1'b0;
      rd_wait_d  = 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (enable && ss_fall) begin
        state_d    = ST_CMD;
        bit_cnt_d  = 3'd0;
        tx_shift_d = 8'h00;
        tx_valid_d = 1'b0;
        rd_wait_d  = 1'b0;
      end
    end else begin
      if (sample_edge) begin
        rx_shift_d = rx_next;
        bit_cnt_d  = bit_cnt_q + 3'd1;
      end

      if (byte_done) begin
        case (state_q)
          ST_CMD: begin
            addr_d = rx_next[ADDR_WIDTH-1:0];
            if (rx_next[7]) begin
              state_d = ST_WRITE;
            end else begin
              state_d = ST_READ;
              req_d   = 1'b1;
              we_d    = 1'b0;
            end
          end
          ST_WRITE: begin
            if (req_q && !bus.reg_gnt) begin
              err_d = 1'b1;
            end else begin
              req_d   = 1'b1;
              we_d    = 1'b1;
              wdata_d = rx_next;
            end
          end
          default: ;
        endcase
      end

      if (shift_edge) begin
        if (load_point) begin
          if (state_q == ST_READ) begin
            if (tx_valid_q) begin
              tx_shift_d = tx_buf_q;
            end else begin
              tx_shift_d = 8'hFF;
              err_d      = 1'b1;
            end
            tx_valid_d = 1'b0;
            if (!req_q) begin
              req_d = 1'b1;
              we_d  = 1'b0;
            end
          end else begin
            tx_shift_d = 8'h00;
          end
        end else begin
          tx_shift_d = data_order ? {tx_shift_q[6:0], 1'b0} : {1'b0, tx_shift_q[7:1]};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 8'h00;
      tx_shift_q  <= 8'h00;
      tx_buf_q    <= 8'h00;
      tx_valid_q  <= 1'b0;
      rd_wait_q   <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 8'h00;
      oe_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ss_prev_q   <= ss_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      tx_buf_q    <= tx_buf_d;
      tx_valid_q  <= tx_valid_d;
      rd_wait_q   <= rd_wait_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      oe_q        <= oe_d;
      err_q       <= err_d;
    end
  end

  assign miso_o        = oe_q & (data_order ? tx_shift_q[7] : tx_shift_q[0]);
  assign miso_oe       = oe_q;
  assign busy          = in_frame | req_q;
  assign err           = err_q;
  assign bus.reg_req   = req_q;
  assign bus.reg_we    = we_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;

endmodule

// File: tb/tb_adam_periph_spi_target.sv
// tb/tb_adam_periph_spi_target.sv - directed bench for the SPI target with a register-file model
module tb_adam_periph_spi_target;
  localparam int H = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic cpol = 1'b0;
  logic cpha = 1'b0;
  logic order = 1'b1;
  logic sclk = 1'b0;
  logic ss_n = 1'b1;
  logic mosi = 1'b0;
  logic miso, miso_oe, busy, err;

  adam_periph_spi_target_if #(.ADDR_WIDTH(7)) bus ();

  adam_periph_spi_target #(.SYNC_STAGES(2), .ADDR_WIDTH(7)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .clock_polarity(cpol), .clock_phase(cpha), .data_order(order),
    .sclk_i(sclk), .ss_n_i(ss_n), .mosi_i(mosi),
    .miso_o(miso), .miso_oe(miso_oe), .bus(bus), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int err_cnt = 0;
  logic [7:0] mem [0:127];
  logic [6:0] wr_addr [$];
  logic [7:0] wr_data [$];
  int gnt_delay = 2;
  bit gnt_en = 1'b1;
  int slow_reads = 0;
  logic [7:0] tx [0:3];
  logic [7:0] rx [0:3];

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic       order;
    logic [7:0] e0;
    logic [7:0] e1;
    logic [7:0] e2;
    int         e_err;
  } vec_t;
  vec_t vt [8];

  always @(negedge clk) if (rst_n && err) err_cnt++;

  initial begin : mem_model
    logic [6:0] a;
    logic       w;
    logic [7:0] d;
    bus.reg_gnt = 1'b0;
    bus.reg_rvalid = 1'b0;
    bus.reg_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (bus.reg_req && gnt_en) begin
        repeat (gnt_delay) @(posedge clk);
        #1 bus.reg_gnt = 1'b1;
        a = bus.reg_addr; w = bus.reg_we; d = bus.reg_wdata;
        @(posedge clk); #1 bus.reg_gnt = 1'b0;
        if (w) begin
          wr_addr.push_back(a);
          wr_data.push_back(d);
        end else begin
          if (slow_reads > 0) begin
            repeat (100) @(posedge clk);
            #1 slow_reads--;
          end
          bus.reg_rvalid = 1'b1;
          bus.reg_rdata = mem[a];
          @(posedge clk); #1 bus.reg_rvalid = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_test();
    wr_addr.delete();
    wr_data.delete();
    sclk = cpol;
    repeat (10) @(negedge clk);
    err_cnt = 0;
  endtask

  task automatic spi_frame(input int nbytes, input int cut_bits);
    int total;
    logic [7:0] cur;
    total = nbytes * 8 + cut_bits;
    for (int i = 0; i < 4; i++) rx[i] = 8'h00;
    sclk = cpol;
    @(negedge clk);
    ss_n = 1'b0;
    repeat (H) @(negedge clk);
    chk("miso_oe_in_frame", miso_oe, 1);
    for (int k = 0; k < total; k++) begin
      int bi;
      int pos;
      bi = k / 8;
      pos = order ? 7 - (k % 8) : (k % 8);
      cur = tx[bi];
      if (!cpha) begin
        mosi = cur[pos];
        repeat (H) @(negedge clk);
        rx[bi][pos] = miso;
        sclk = ~cpol;
        repeat (H) @(negedge clk);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = cur[pos];
        repeat (H) @(negedge clk);
        rx[bi][pos] = miso;
        sclk = cpol;
        repeat (H) @(negedge clk);
      end
    end
    repeat (H) @(negedge clk);
    ss_n = 1'b1;
    mosi = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    repeat (4) @(negedge clk);
    while ((busy || bus.reg_req) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk(name, busy, 0);
    repeat (20) @(negedge clk);
  endtask

  task automatic chk_writes(input string name, input int n,
                            input logic [6:0] a0, input logic [7:0] d0,
                            input logic [6:0] a1, input logic [7:0] d1);
    chk({name, "_count"}, wr_addr.size(), n);
    if (n > 0 && wr_addr.size() > 0) begin
      chk({name, "_addr0"}, wr_addr[0], a0);
      chk({name, "_data0"}, wr_data[0], d0);
    end
    if (n > 1 && wr_addr.size() > 1) begin
      chk({name, "_addr1"}, wr_addr[1], a1);
      chk({name, "_data1"}, wr_data[1], d1);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[16] = 8'hA5;
    mem[17] = 8'h3C;
    vt[0] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'hA5, 8'h3C, 0};
    vt[1] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'hA5, 8'h3C, 0};
    vt[2] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'hA5, 8'h3C, 0};
    vt[3] = '{1'b1, 1'b1, 1'b1, 8'h00, 8'hA5, 8'h3C, 0};
    vt[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'hA5, 8'h3C, 0};
    vt[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hA5, 8'h3C, 0};
    vt[6] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'hA5, 8'h3C, 0};
    vt[7] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'hA5, 8'h3C, 0};

    repeat (4) @(negedge clk);
    chk("rst_miso", miso, 0);
    chk("rst_miso_oe", miso_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_req", bus.reg_req, 0);
    chk("rst_we", bus.reg_we, 0);
    chk("rst_addr", bus.reg_addr, 0);
    chk("rst_wdata", bus.reg_wdata, 0);
    rst_n = 1'b1;
    enable = 1'b1;
    repeat (4) @(negedge clk);

    // Basic write frame, mode 0, MSB first.
    cpol = 0; cpha = 0; order = 1;
    start_test();
    tx[0] = 8'h85; tx[1] = 8'h11; tx[2] = 8'h22;
    spi_frame(3, 0);
    wait_idle("wr_idle");
    chk_writes("wr_basic", 2, 7'h05, 8'h11, 7'h06, 8'h22);
    chk("wr_basic_err", err_cnt, 0);

    // Read frame in every mode and bit order.
    for (int v = 0; v < 8; v++) begin
      cpol = vt[v].cpol; cpha = vt[v].cpha; order = vt[v].order;
      start_test();
      tx[0] = 8'h10; tx[1] = 8'h00; tx[2] = 8'h00;
      spi_frame(3, 0);
      wait_idle("rd_idle");
      chk($sformatf("rd_v%0d_b0", v), rx[0], vt[v].e0);
      chk($sformatf("rd_v%0d_b1", v), rx[1], vt[v].e1);
      chk($sformatf("rd_v%0d_b2", v), rx[2], vt[v].e2);
      chk($sformatf("rd_v%0d_err", v), err_cnt, vt[v].e_err);
    end

    // Address wrap at the top of the register space.
    cpol = 0; cpha = 0; order = 1;
    start_test();
    tx[0] = 8'hFF; tx[1] = 8'hAA; tx[2] = 8'hBB;
    spi_frame(3, 0);
    wait_idle("wrap_idle");
    chk_writes("wrap", 2, 7'h7F, 8'hAA, 7'h00, 8'hBB);
    chk("wrap_err", err_cnt, 0);

    // Late read data causes an underrun on the first data byte.
    start_test();
    slow_reads = 1;
    tx[0] = 8'h10; tx[1] = 8'h00;
    spi_frame(2, 0);
    wait_idle("urun_idle");
    chk("urun_b0", rx[0], 8'h00);
    chk("urun_b1", rx[1], 8'hFF);
    chk("urun_err", err_cnt, 1);

    // Frame cut after 3 bits of the second byte, then a clean frame.
    start_test();
    tx[0] = 8'h85; tx[1] = 8'h11;
    spi_frame(1, 3);
    wait_idle("cut_idle");
    chk_writes("cut", 0, 7'h00, 8'h00, 7'h00, 8'h00);
    chk("cut_err", err_cnt, 1);
    start_test();
    spi_frame(2, 0);
    wait_idle("after_cut_idle");
    chk_writes("after_cut", 1, 7'h05, 8'h11, 7'h00, 8'h00);
    chk("after_cut_err", err_cnt, 0);

    // Grant withheld: the second data byte is dropped.
    start_test();
    gnt_en = 1'b0;
    tx[0] = 8'h85; tx[1] = 8'h11; tx[2] = 8'h22;
    spi_frame(3, 0);
    repeat (10) @(negedge clk);
    chk("drop_busy_pending", busy, 1);
    gnt_en = 1'b1;
    wait_idle("drop_idle");
    chk_writes("drop", 1, 7'h05, 8'h11, 7'h00, 8'h00);
    chk("drop_err", err_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end
endmodule
